// File: rtl/fft_frame_buffer_pkg.sv
// Shared constants, FSM encodings and sample type for the FFT frame buffer.
package fft_frame_buffer_pkg;

  localparam int FFT_Q      = 15;
  localparam int FFT_N      = 256;
  localparam int FFT_ADDR_W = $clog2(FFT_N);

  // Read-side FSM encodings
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ANNOUNCE = 2'd1;
  localparam logic [1:0] ST_SERVE    = 2'd2;

  typedef logic signed [FFT_Q:0] sample_t;

  // Bit-reversed sample index, the order FFT stage 1 usually reads in
  function automatic logic [FFT_ADDR_W-1:0] bit_reverse(input logic [FFT_ADDR_W-1:0] idx);
    logic [FFT_ADDR_W-1:0] r;
    for (int i = 0; i < FFT_ADDR_W; i++) begin
      r[i] = idx[FFT_ADDR_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_buffer_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks; address is {bank, idx}.
// One write port and one registered read port, no reset on the array so it
// maps onto block RAM.
module fft_frame_buffer_bank_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port, updated only on an accepted request
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame store feeding FFT stage 1. The writer fills one bank while
// the reader serves random-access requests from the other. Frames are
// announced with a one-cycle valid_packet and released after N requests.
module fft_frame_buffer
  import fft_frame_buffer_pkg::*;
#(
  parameter int Q      = FFT_Q,
  parameter int N      = FFT_N,
  parameter int ADDR_W = FFT_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  logic signed [Q:0]   data_in,
  input  logic                req_valid,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                valid_packet,
  output logic                valid_out,
  output logic signed [Q:0]   data_out,
  output logic                overrun
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(N-1);

  logic [1:0]      full_reg;
  logic            wr_bank_reg;
  logic            rd_bank_reg;
  logic [ADDR_W:0] wr_cnt_reg;
  logic [ADDR_W:0] srv_cnt_reg;
  logic [1:0]      state_reg;
  logic            valid_packet_reg;
  logic            valid_out_reg;
  logic            overrun_reg;
  logic [Q:0]      ram_q;

  logic wr_accept;
  logic wr_last;
  logic rd_accept;
  logic rd_last;

  assign wr_accept = valid_in && !full_reg[wr_bank_reg];
  assign wr_last   = wr_accept && (wr_cnt_reg == LAST_IDX);
  assign rd_accept = (state_reg == ST_SERVE) && req_valid;
  assign rd_last   = rd_accept && (srv_cnt_reg == LAST_IDX);

  fft_frame_buffer_bank_ram #(
    .WIDTH (Q + 1),
    .DEPTH (2 * N),
    .AW    (ADDR_W + 1)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr ({wr_bank_reg, wr_cnt_reg[ADDR_W-1:0]}),
    .wr_data (data_in),
    .rd_en   (rd_accept),
    .rd_addr ({rd_bank_reg, req_addr}),
    .rd_data (ram_q)
  );

  // Write side: fill the current bank, hop to the other bank on the last sample
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_reg <= 1'b0;
      wr_cnt_reg  <= '0;
    end else if (wr_accept) begin
      if (wr_last) begin
        wr_bank_reg <= ~wr_bank_reg;
        wr_cnt_reg  <= '0;
      end else begin
        wr_cnt_reg <= wr_cnt_reg + 1'b1;
      end
    end
  end

  // Full flags: writer sets, reader clears; they never target the same bank
  // on one edge, so both updates can land together
  always_ff @(posedge clk) begin
    if (reset) begin
      full_reg <= 2'b00;
    end else begin
      if (wr_last) begin
        full_reg[wr_bank_reg] <= 1'b1;
      end
      if (rd_last) begin
        full_reg[rd_bank_reg] <= 1'b0;
      end
    end
  end

  // Read FSM: wait for a full bank, announce it, serve N requests, release
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      rd_bank_reg      <= 1'b0;
      srv_cnt_reg      <= '0;
      valid_packet_reg <= 1'b0;
    end else begin
      valid_packet_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (full_reg[rd_bank_reg]) begin
            state_reg        <= ST_ANNOUNCE;
            valid_packet_reg <= 1'b1;
          end
        end
        ST_ANNOUNCE: begin
          srv_cnt_reg <= '0;
          state_reg   <= ST_SERVE;
        end
        ST_SERVE: begin
          if (req_valid) begin
            srv_cnt_reg <= srv_cnt_reg + 1'b1;
            if (srv_cnt_reg == LAST_IDX) begin
              rd_bank_reg <= ~rd_bank_reg;
              state_reg   <= ST_IDLE;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Response and drop strobes, one cycle after the triggering input
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      valid_out_reg <= rd_accept;
      overrun_reg   <= valid_in && full_reg[wr_bank_reg];
    end
  end

  assign valid_packet = valid_packet_reg;
  assign valid_out    = valid_out_reg;
  assign overrun      = overrun_reg;
  // RAM output register has no reset; hold data_out at zero outside a response
  assign data_out     = valid_out_reg ? $signed(ram_q) : '0;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Scoreboard bench for fft_frame_buffer: stimulus pushes expected read data,
// a negedge monitor pops and compares on every valid_out.
module tb_fft_frame_buffer;
  import fft_frame_buffer_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_in;
  logic signed [15:0] data_in;
  logic              req_valid;
  logic [7:0]        req_addr;
  logic              valid_packet;
  logic              valid_out;
  logic signed [15:0] data_out;
  logic              overrun;

  int vectors     = 0;
  int miscompares = 0;
  int pkt_seen    = 0;
  int ovr_seen    = 0;
  logic [15:0] exp_q[$];

  fft_frame_buffer #(.Q(15), .N(256), .ADDR_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .valid_packet (valid_packet),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic write_sample(input int value);
    valid_in = 1'b1;
    data_in  = 16'(value);
  endtask

  task automatic request(input logic [7:0] addr, input int value);
    req_valid = 1'b1;
    req_addr  = addr;
    exp_q.push_back(16'(value));
  endtask

  task automatic idle_inputs();
    valid_in  = 1'b0;
    req_valid = 1'b0;
  endtask

  // Monitor: every response must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (valid_out) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid_out: got data %0d, expected no response", data_out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          miscompares++;
          $display("FAIL read_data: got %0d, expected %0d", data_out, $signed(e));
        end else begin
          $display("read ok data=%0d", data_out);
        end
      end
    end
    if (valid_packet) pkt_seen++;
    if (overrun) ovr_seen++;
  end

  initial begin
    reset = 1'b1; valid_in = 1'b0; data_in = '0; req_valid = 1'b0; req_addr = '0;

    // Reset state
    tick(); tick();
    check("reset_valid_packet", 32'(valid_packet), 0);
    check("reset_valid_out", 32'(valid_out), 0);
    check("reset_overrun", 32'(overrun), 0);
    check("reset_data_out", 32'(data_out), 0);
    reset = 1'b0;

    // 1. One frame of data_in = i, announce 2 cycles after last write
    for (int i = 0; i < 256; i++) begin
      write_sample(i);
      tick();
    end
    idle_inputs();
    check("t1_no_early_packet", 32'(valid_packet), 0);
    tick();
    check("t1_packet", 32'(valid_packet), 1);
    tick();
    check("t1_packet_one_cycle", 32'(valid_packet), 0);

    // 2. Bit-reversed back-to-back reads
    for (int k = 0; k < 256; k++) begin
      request(bit_reverse(8'(k)), int'(bit_reverse(8'(k))));
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_no_packet_empty", 32'(valid_packet), 0);
    end

    // 3. Both banks full, then overrun; drain in order
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 513; i++) begin
      write_sample(2000 + i);
      tick();
    end
    check("t3_overrun_sample513", 32'(overrun), 1);
    idle_inputs();
    tick();
    check("t3_overrun_pulse", 32'(overrun), 0);
    for (int k = 0; k < 256; k++) begin
      request(8'(k), 2000 + k);
      if (k == 255) write_sample(9999);  // arrives in the release cycle
      tick();
    end
    idle_inputs();
    check("t3_release_cycle_drop", 32'(overrun), 1);
    check("t3_no_early_packet", 32'(valid_packet), 0);
    tick();
    check("t3_bank1_packet", 32'(valid_packet), 1);
    tick();
    for (int k = 0; k < 256; k++) begin
      request(8'(255 - k), 2256 + 255 - k);
      tick();
    end
    idle_inputs();
    tick();

    // 4. Requests in IDLE with an empty buffer are ignored
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1;
      req_addr  = 8'(k);
      tick();
      check("t4_idle_no_valid_out", 32'(valid_out), 0);
    end
    idle_inputs();

    // 5. Requests in IDLE/ANNOUNCE ignored; release coincides with bank 1 completion
    for (int i = 0; i < 256; i++) begin
      write_sample(3000 + i);
      tick();
    end
    valid_in = 1'b0;
    req_valid = 1'b1; req_addr = 8'd0;
    check("t5_no_early_packet", 32'(valid_packet), 0);
    tick();
    check("t5_packet", 32'(valid_packet), 1);
    check("t5_idle_req_ignored", 32'(valid_out), 0);
    req_addr = 8'd1;
    tick();
    check("t5_announce_req_ignored", 32'(valid_out), 0);
    for (int k = 0; k < 256; k++) begin
      write_sample(4000 + k);
      request(8'(255 - k), 3000 + 255 - k);
      tick();
    end
    idle_inputs();
    check("t5_no_overrun", 32'(ovr_seen), 2);
    check("t5_no_early_packet_b1", 32'(valid_packet), 0);
    tick();
    check("t5_bank1_packet", 32'(valid_packet), 1);
    tick();
    for (int k = 0; k < 256; k++) begin
      logic [7:0] a;
      a = (k < 4) ? 8'd7 : 8'((k * 3) % 256);
      request(a, 4000 + int'(a));
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_packet_after", 32'(valid_packet), 0);
    end

    // 6. Reset mid-frame and mid-read, then a fresh frame
    for (int i = 0; i < 256; i++) begin
      write_sample(5000 + i);
      tick();
    end
    idle_inputs();
    tick();
    check("t6_packet", 32'(valid_packet), 1);
    tick();
    for (int k = 0; k < 100; k++) begin
      write_sample(6000 + k);
      if (k < 10) request(8'(k), 5000 + k);
      else req_valid = 1'b0;
      tick();
    end
    idle_inputs();
    reset = 1'b1;
    tick();
    check("t6_reset_valid_packet", 32'(valid_packet), 0);
    check("t6_reset_valid_out", 32'(valid_out), 0);
    check("t6_reset_overrun", 32'(overrun), 0);
    check("t6_reset_data_out", 32'(data_out), 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      write_sample(-20000 + i);
      tick();
    end
    idle_inputs();
    check("t6_no_early_packet", 32'(valid_packet), 0);
    tick();
    check("t6_fresh_packet", 32'(valid_packet), 1);
    tick();
    for (int k = 0; k < 256; k++) begin
      request(8'(k), -20000 + k);
      tick();
    end
    idle_inputs();
    tick(); tick(); tick();

    check("end_outstanding_requests", 32'(exp_q.size()), 0);
    check("end_packet_count", 32'(pkt_seen), 7);
    check("end_overrun_count", 32'(ovr_seen), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
